// File: rtl/arty_dma_gate_pkg.sv
// Shared types and constants for the Arty DMA gate that sits between the core
// DMA port and the cache-to-AXI translator in front of the MIG.
package arty_dma_gate_pkg;

  localparam int ddr_addr_width_c  = 28;
  localparam int dma_daddr_width_c = 28;

  typedef enum logic [0:0] {
    e_wait_calib = 1'b0,
    e_run        = 1'b1
  } gate_state_e;

  typedef struct packed {
    logic                         write_not_read;
    logic [dma_daddr_width_c-1:0] addr;
  } dma_pkt_s;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arty_dma_gate_tracker.sv
// Per-direction outstanding-block counter with an intra-block beat counter and a
// sticky flag for beats that arrive while nothing is owed.
module arty_dma_gate_tracker
  import arty_dma_gate_pkg::*;
#(
  parameter int max_blocks_p = 2,
  parameter int block_size_p = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic accept_i,
  input  logic beat_i,
  output logic empty_o,
  output logic full_o,
  output logic last_o,
  output logic error_o
);

  localparam int blk_w_lp  = ctr_width(max_blocks_p + 1);
  localparam int beat_w_lp = ctr_width(block_size_p);
  localparam logic [blk_w_lp-1:0]  max_lp  = blk_w_lp'(max_blocks_p);
  localparam logic [beat_w_lp-1:0] last_lp = beat_w_lp'(block_size_p - 1);

  logic [blk_w_lp-1:0]  blocks_r, blocks_n;
  logic [beat_w_lp-1:0] beat_r, beat_n;
  logic                 error_r;
  logic                 empty_s, underflow_s, last_s;

  // Next-state for block and beat counters; an unowed beat leaves both untouched.
  always_comb begin
    empty_s     = (blocks_r == {blk_w_lp{1'b0}});
    underflow_s = beat_i & empty_s;
    last_s      = beat_i & ~empty_s & (beat_r == last_lp);
    beat_n      = beat_r;
    blocks_n    = blocks_r;
    if (beat_i & ~empty_s) begin
      if (beat_r == last_lp) begin
        beat_n = {beat_w_lp{1'b0}};
      end else begin
        beat_n = beat_r + 1'b1;
      end
    end else begin
      beat_n = beat_r;
    end
    case ({accept_i, last_s})
      2'b10:   blocks_n = blocks_r + 1'b1;
      2'b01:   blocks_n = blocks_r - 1'b1;
      default: blocks_n = blocks_r;
    endcase
  end

  // Counter and sticky-error registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      blocks_r <= {blk_w_lp{1'b0}};
      beat_r   <= {beat_w_lp{1'b0}};
      error_r  <= 1'b0;
    end else begin
      blocks_r <= blocks_n;
      beat_r   <= beat_n;
      error_r  <= error_r | underflow_s;
    end
  end

  assign empty_o = empty_s;
  assign full_o  = (blocks_r == max_lp);
  assign last_o  = last_s;
  assign error_o = error_r;

  arty_dma_gate_tracker_chk #(
    .max_blocks_p(max_blocks_p),
    .blk_w_p     (blk_w_lp)
  ) chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (accept_i),
    .dec_i   (last_s),
    .blocks_i(blocks_r)
  );

endmodule

// File: rtl/arty_dma_gate_tracker_chk.sv
// Occupancy checks for one direction's block counter; kept out of the
// datapath so the tracker stays purely synthesizable logic.
module arty_dma_gate_tracker_chk #(
  parameter int max_blocks_p = 2,
  parameter int blk_w_p      = 2
) (
  input logic               clk_i,
  input logic               reset_i,
  input logic               inc_i,
  input logic               dec_i,
  input logic [blk_w_p-1:0] blocks_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (inc_i && !dec_i) |-> (blocks_i != blk_w_p'(max_blocks_p)));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (dec_i && !inc_i) |-> (blocks_i != {blk_w_p{1'b0}}));

endmodule

// File: rtl/arty_dma_gate.sv
// Holds DRAM DMA traffic until MIG calibration completes, bounds outstanding
// read/write blocks, wraps addresses into the DDR window and drives status LEDs.
module arty_dma_gate
  import arty_dma_gate_pkg::*;
#(
  parameter int daddr_width_p         = dma_daddr_width_c,
  parameter int dram_addr_width_p     = ddr_addr_width_c,
  parameter int data_width_p          = 64,
  parameter int block_size_in_words_p = 8,
  parameter int max_rd_blocks_p       = 2,
  parameter int max_wr_blocks_p       = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     calib_done_i,
  input  logic [daddr_width_p:0]   core_dma_pkt_i,
  input  logic                     core_dma_pkt_v_i,
  output logic                     core_dma_pkt_yumi_o,
  output logic [daddr_width_p:0]   mem_dma_pkt_o,
  output logic                     mem_dma_pkt_v_o,
  input  logic                     mem_dma_pkt_yumi_i,
  input  logic [data_width_p-1:0]  mem_dma_data_i,
  input  logic                     mem_dma_data_v_i,
  output logic                     mem_dma_data_ready_and_o,
  output logic [data_width_p-1:0]  core_dma_data_o,
  output logic                     core_dma_data_v_o,
  input  logic                     core_dma_data_ready_and_i,
  input  logic [data_width_p-1:0]  core_dma_data_i,
  input  logic                     core_dma_data_v_i,
  output logic                     core_dma_data_yumi_o,
  output logic [data_width_p-1:0]  mem_dma_data_o,
  output logic                     mem_dma_data_v_o,
  input  logic                     mem_dma_data_yumi_i,
  output logic                     addr_error_o,
  output logic                     rd_error_o,
  output logic                     wr_error_o,
  output logic                     done_o
);

  typedef struct packed {
    logic                     write_not_read;
    logic [daddr_width_p-1:0] addr;
  } pkt_s;

  localparam logic [daddr_width_p-1:0] keep_mask_lp =
    daddr_width_p'({dram_addr_width_p{1'b1}});

  gate_state_e state_r, state_n;
  logic        sync_meta_r, sync_r;
  logic        addr_error_r, seen_complete_r, done_r;
  pkt_s        core_pkt_s, mem_pkt_s;
  logic        run_s, stall_s, addr_oob_s;
  logic        pkt_v_s, pkt_accept_s, rd_accept_s, wr_accept_s;
  logic        rd_beat_s, wr_fire_s, wr_spur_s, wr_v_s;
  logic        rd_empty_s, rd_full_s, rd_last_s;
  logic        wr_empty_s, wr_full_s, wr_last_s;

  assign core_pkt_s = core_dma_pkt_i;

  // Calibration synchronizer, run-state register and sticky status flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_meta_r     <= 1'b0;
      sync_r          <= 1'b0;
      state_r         <= e_wait_calib;
      addr_error_r    <= 1'b0;
      seen_complete_r <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      sync_meta_r     <= calib_done_i;
      sync_r          <= sync_r | sync_meta_r;
      state_r         <= state_n;
      addr_error_r    <= addr_error_r | (pkt_accept_s & addr_oob_s);
      seen_complete_r <= seen_complete_r | rd_last_s | wr_last_s;
      done_r          <= sync_r & seen_complete_r & rd_empty_s & wr_empty_s;
    end
  end

  // Gate FSM: once calibrated the gate stays open until reset.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_wait_calib: begin
        if (sync_r) begin
          state_n = e_run;
        end else begin
          state_n = e_wait_calib;
        end
      end
      e_run:   state_n = e_run;
      default: state_n = e_wait_calib;
    endcase
  end

  // Packet and data handshakes, all forced idle until the gate is open.
  always_comb begin
    run_s                    = (state_r == e_run);
    mem_pkt_s.write_not_read = core_pkt_s.write_not_read;
    mem_pkt_s.addr           = core_pkt_s.addr & keep_mask_lp;
    addr_oob_s               = |(core_pkt_s.addr & ~keep_mask_lp);
    if (core_pkt_s.write_not_read) begin
      stall_s = wr_full_s;
    end else begin
      stall_s = rd_full_s;
    end
    pkt_v_s      = run_s & core_dma_pkt_v_i & ~stall_s;
    pkt_accept_s = pkt_v_s & mem_dma_pkt_yumi_i;
    rd_accept_s  = pkt_accept_s & ~core_pkt_s.write_not_read;
    wr_accept_s  = pkt_accept_s & core_pkt_s.write_not_read;
    rd_beat_s    = run_s & mem_dma_data_v_i & core_dma_data_ready_and_i;
    // Write beats with nothing owed are swallowed so the core cannot hang.
    wr_v_s       = run_s & core_dma_data_v_i & ~wr_empty_s;
    wr_fire_s    = wr_v_s & mem_dma_data_yumi_i;
    wr_spur_s    = run_s & core_dma_data_v_i & wr_empty_s;
  end

  arty_dma_gate_tracker #(
    .max_blocks_p(max_rd_blocks_p),
    .block_size_p(block_size_in_words_p)
  ) rd_tracker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .accept_i(rd_accept_s),
    .beat_i  (rd_beat_s),
    .empty_o (rd_empty_s),
    .full_o  (rd_full_s),
    .last_o  (rd_last_s),
    .error_o (rd_error_o)
  );

  arty_dma_gate_tracker #(
    .max_blocks_p(max_wr_blocks_p),
    .block_size_p(block_size_in_words_p)
  ) wr_tracker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .accept_i(wr_accept_s),
    .beat_i  (wr_fire_s | wr_spur_s),
    .empty_o (wr_empty_s),
    .full_o  (wr_full_s),
    .last_o  (wr_last_s),
    .error_o (wr_error_o)
  );

  assign mem_dma_pkt_o            = mem_pkt_s;
  assign mem_dma_pkt_v_o          = pkt_v_s;
  assign core_dma_pkt_yumi_o      = pkt_accept_s;
  assign core_dma_data_o          = mem_dma_data_i;
  assign core_dma_data_v_o        = run_s & mem_dma_data_v_i;
  assign mem_dma_data_ready_and_o = run_s & core_dma_data_ready_and_i;
  assign mem_dma_data_o           = core_dma_data_i;
  assign mem_dma_data_v_o         = wr_v_s;
  assign core_dma_data_yumi_o     = wr_fire_s | wr_spur_s;
  assign addr_error_o             = addr_error_r;
  assign done_o                   = done_r;

endmodule

// File: tb/tb_arty_dma_gate.sv
// Directed bench for arty_dma_gate: calibration hold, burst bookkeeping, address
// wrap, spurious beats and reset mid-burst, with a wide packet address to exercise wrap.
module tb_arty_dma_gate;

  localparam int DAW = 32;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           reset_i, calib_done_i;
  logic [DAW:0]   core_dma_pkt_i, mem_dma_pkt_o;
  logic           core_dma_pkt_v_i, core_dma_pkt_yumi_o, mem_dma_pkt_v_o, mem_dma_pkt_yumi_i;
  logic [DW-1:0]  mem_dma_data_i, core_dma_data_o, core_dma_data_i, mem_dma_data_o;
  logic           mem_dma_data_v_i, mem_dma_data_ready_and_o, core_dma_data_v_o;
  logic           core_dma_data_ready_and_i, core_dma_data_v_i, core_dma_data_yumi_o;
  logic           mem_dma_data_v_o, mem_dma_data_yumi_i;
  logic           addr_error_o, rd_error_o, wr_error_o, done_o;

  int errors = 0;
  int checks = 0;

  arty_dma_gate #(.daddr_width_p(DAW)) dut (
    .clk_i(clk), .reset_i(reset_i), .calib_done_i(calib_done_i),
    .core_dma_pkt_i(core_dma_pkt_i), .core_dma_pkt_v_i(core_dma_pkt_v_i),
    .core_dma_pkt_yumi_o(core_dma_pkt_yumi_o),
    .mem_dma_pkt_o(mem_dma_pkt_o), .mem_dma_pkt_v_o(mem_dma_pkt_v_o),
    .mem_dma_pkt_yumi_i(mem_dma_pkt_yumi_i),
    .mem_dma_data_i(mem_dma_data_i), .mem_dma_data_v_i(mem_dma_data_v_i),
    .mem_dma_data_ready_and_o(mem_dma_data_ready_and_o),
    .core_dma_data_o(core_dma_data_o), .core_dma_data_v_o(core_dma_data_v_o),
    .core_dma_data_ready_and_i(core_dma_data_ready_and_i),
    .core_dma_data_i(core_dma_data_i), .core_dma_data_v_i(core_dma_data_v_i),
    .core_dma_data_yumi_o(core_dma_data_yumi_o),
    .mem_dma_data_o(mem_dma_data_o), .mem_dma_data_v_o(mem_dma_data_v_o),
    .mem_dma_data_yumi_i(mem_dma_data_yumi_i),
    .addr_error_o(addr_error_o), .rd_error_o(rd_error_o),
    .wr_error_o(wr_error_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pv;
    logic [DAW:0]  pkt;
    logic          pyumi;
    logic          mdv;
    logic [DW-1:0] mdata;
    logic          crdy;
    logic          cdv;
    logic [DW-1:0] cdata;
    logic          mdyumi;
    logic          e_pv;
    logic [DAW:0]  e_pkt;
    logic          e_pyumi;
    logic          e_cdv;
    logic [DW-1:0] e_cdata;
    logic          e_mdv;
    logic [DW-1:0] e_mdata;
    logic          e_cyumi;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic pv, input logic [DAW:0] pkt, input logic pyumi,
                              input logic mdv, input logic [DW-1:0] mdata, input logic crdy,
                              input logic cdv, input logic [DW-1:0] cdata, input logic mdyumi,
                              input logic e_pv, input logic [DAW:0] e_pkt, input logic e_pyumi,
                              input logic e_cdv, input logic e_mdv, input logic e_cyumi);
    vec_t v;
    v.pv = pv; v.pkt = pkt; v.pyumi = pyumi; v.mdv = mdv; v.mdata = mdata; v.crdy = crdy;
    v.cdv = cdv; v.cdata = cdata; v.mdyumi = mdyumi;
    v.e_pv = e_pv; v.e_pkt = e_pkt; v.e_pyumi = e_pyumi;
    v.e_cdv = e_cdv; v.e_cdata = mdata; v.e_mdv = e_mdv; v.e_mdata = cdata; v.e_cyumi = e_cyumi;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_dma_pkt_v_i = 1'b0; mem_dma_pkt_yumi_i = 1'b0;
    mem_dma_data_v_i = 1'b0; core_dma_data_ready_and_i = 1'b0;
    core_dma_data_v_i = 1'b0; mem_dma_data_yumi_i = 1'b0;
  endtask

  // Wait for the gate to forward the pending packet; returns cycles waited or 99 on timeout.
  task automatic wait_open(output int lat);
    lat = 99;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (mem_dma_pkt_v_o === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic bad;
    vec_t v;

    // ---------------- reset and calibration hold ----------------
    reset_i = 1'b1; calib_done_i = 1'b0;
    core_dma_pkt_i = {1'b0, 32'h0000_0100}; core_dma_pkt_v_i = 1'b1;
    mem_dma_pkt_yumi_i = 1'b0;
    mem_dma_data_i = 64'h0; mem_dma_data_v_i = 1'b1; core_dma_data_ready_and_i = 1'b1;
    core_dma_data_i = 64'h0; core_dma_data_v_i = 1'b1; mem_dma_data_yumi_i = 1'b0;
    repeat (3) step();
    check("reset_pkt_v", mem_dma_pkt_v_o, 1'b0);
    check("reset_pkt_yumi", core_dma_pkt_yumi_o, 1'b0);
    check("reset_handshakes", {mem_dma_data_ready_and_o, core_dma_data_v_o,
                               core_dma_data_yumi_o, mem_dma_data_v_o}, 4'b0000);
    check("reset_flags", {addr_error_o, rd_error_o, wr_error_o, done_o}, 4'b0000);

    reset_i = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({mem_dma_pkt_v_o, core_dma_pkt_yumi_o, core_dma_data_v_o, mem_dma_data_v_o,
           core_dma_data_yumi_o, mem_dma_data_ready_and_o} !== 6'b000000) bad = 1'b1;
    end
    check("wait_calib_hold", bad, 1'b0);
    check("wait_calib_flags", {addr_error_o, rd_error_o, wr_error_o, done_o}, 4'b0000);

    mem_dma_data_v_i = 1'b0; core_dma_data_v_i = 1'b0;
    calib_done_i = 1'b1;
    wait_open(lat);
    check("calib_latency_ok", (lat >= 2 && lat <= 3), 1'b1);
    check("first_pkt_addr", mem_dma_pkt_o, {1'b0, 32'h0000_0100});
    mem_dma_pkt_yumi_i = 1'b1;
    #1;
    check("first_pkt_yumi", core_dma_pkt_yumi_o, 1'b1);
    step();
    core_dma_pkt_v_i = 1'b0; mem_dma_pkt_yumi_i = 1'b0;
    #1;
    check("first_pkt_yumi_pulse", core_dma_pkt_yumi_o, 1'b0);

    // ---------------- one full read block ----------------
    for (int i = 0; i < 8; i++) begin
      mem_dma_data_v_i = 1'b1; mem_dma_data_i = 64'hBEEF_0000 + 64'(i);
      core_dma_data_ready_and_i = 1'b1;
      #1;
      check($sformatf("rd_beat%0d", i), {core_dma_data_v_o, core_dma_data_o},
            {1'b1, 64'hBEEF_0000 + 64'(i)});
      step();
    end
    idle_inputs();
    #1;
    check("done_not_yet", done_o, 1'b0);
    step();
    check("done_after_block", done_o, 1'b1);

    // ---------------- table: back-to-back reads, wrapped write, bursts ----------------
    tbl.push_back(mk(1, {1'b0, 32'h40}, 1, 0, 64'h0, 0, 0, 64'h0, 0,
                     1, {1'b0, 32'h40}, 1, 0, 0, 0));
    tbl.push_back(mk(1, {1'b0, 32'h80}, 1, 0, 64'h0, 0, 0, 64'h0, 0,
                     1, {1'b0, 32'h80}, 1, 0, 0, 0));
    tbl.push_back(mk(1, {1'b0, 32'hC0}, 1, 0, 64'h0, 0, 0, 64'h0, 0,
                     0, {1'b0, 32'hC0}, 0, 0, 0, 0));
    tbl.push_back(mk(1, {1'b0, 32'hC0}, 1, 0, 64'h0, 0, 0, 64'h0, 0,
                     0, {1'b0, 32'hC0}, 0, 0, 0, 0));
    tbl.push_back(mk(1, {1'b1, 32'h1000_0080}, 1, 0, 64'h0, 0, 0, 64'h0, 0,
                     1, {1'b1, 32'h0000_0080}, 1, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, {1'b0, 32'hC0}, 0, 1, 64'h1000 + 64'(i), 1, 1, 64'h2000 + 64'(i), 1,
                       0, {1'b0, 32'hC0}, 0, 1, 1, 1));
    tbl.push_back(mk(1, {1'b0, 32'hC0}, 1, 0, 64'h0, 0, 0, 64'h0, 0,
                     1, {1'b0, 32'hC0}, 1, 0, 0, 0));

    foreach (tbl[k]) begin
      v = tbl[k];
      core_dma_pkt_v_i = v.pv; core_dma_pkt_i = v.pkt; mem_dma_pkt_yumi_i = v.pyumi;
      mem_dma_data_v_i = v.mdv; mem_dma_data_i = v.mdata; core_dma_data_ready_and_i = v.crdy;
      core_dma_data_v_i = v.cdv; core_dma_data_i = v.cdata; mem_dma_data_yumi_i = v.mdyumi;
      #1;
      check($sformatf("tbl%0d_pkt_v", k), mem_dma_pkt_v_o, v.e_pv);
      check($sformatf("tbl%0d_pkt_yumi", k), core_dma_pkt_yumi_o, v.e_pyumi);
      if (v.e_pv) check($sformatf("tbl%0d_pkt", k), mem_dma_pkt_o, v.e_pkt);
      check($sformatf("tbl%0d_rd_v", k), core_dma_data_v_o, v.e_cdv);
      if (v.e_cdv) check($sformatf("tbl%0d_rd_data", k), core_dma_data_o, v.e_cdata);
      check($sformatf("tbl%0d_wr_v", k), mem_dma_data_v_o, v.e_mdv);
      if (v.e_mdv) check($sformatf("tbl%0d_wr_data", k), mem_dma_data_o, v.e_mdata);
      check($sformatf("tbl%0d_wr_yumi", k), core_dma_data_yumi_o, v.e_cyumi);
      step();
    end
    idle_inputs();
    #1;
    check("addr_error_sticky", addr_error_o, 1'b1);
    check("wr_error_clean", wr_error_o, 1'b0);
    check("done_with_reads_pending", done_o, 1'b0);

    // drain the two outstanding read blocks
    for (int i = 0; i < 16; i++) begin
      mem_dma_data_v_i = 1'b1; core_dma_data_ready_and_i = 1'b1; mem_dma_data_i = 64'(i);
      step();
    end
    idle_inputs();
    step();
    check("done_after_drain", done_o, 1'b1);
    check("rd_error_clean", rd_error_o, 1'b0);

    // ---------------- spurious beats ----------------
    core_dma_data_v_i = 1'b1; core_dma_data_i = 64'hDEAD;
    #1;
    check("spur_wr_yumi", core_dma_data_yumi_o, 1'b1);
    check("spur_wr_blocked", mem_dma_data_v_o, 1'b0);
    step();
    core_dma_data_v_i = 1'b0;
    #1;
    check("wr_error_set", wr_error_o, 1'b1);
    mem_dma_data_v_i = 1'b1; core_dma_data_ready_and_i = 1'b1; mem_dma_data_i = 64'hF00D;
    #1;
    check("spur_rd_forwarded", {core_dma_data_v_o, core_dma_data_o}, {1'b1, 64'hF00D});
    step();
    idle_inputs();
    #1;
    check("rd_error_set", rd_error_o, 1'b1);
    step();
    check("done_after_spurious", done_o, 1'b1);

    // ---------------- reset mid-burst ----------------
    core_dma_pkt_v_i = 1'b1; core_dma_pkt_i = {1'b0, 32'h200}; mem_dma_pkt_yumi_i = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      mem_dma_data_v_i = 1'b1; core_dma_data_ready_and_i = 1'b1;
      step();
    end
    reset_i = 1'b1;
    core_dma_pkt_v_i = 1'b1; core_dma_pkt_i = {1'b0, 32'h240}; mem_dma_pkt_yumi_i = 1'b0;
    step();
    check("midrst_handshakes", {mem_dma_pkt_v_o, core_dma_pkt_yumi_o, core_dma_data_v_o,
                                mem_dma_data_ready_and_o, mem_dma_data_v_o,
                                core_dma_data_yumi_o}, 6'b000000);
    check("midrst_flags", {addr_error_o, rd_error_o, wr_error_o, done_o}, 4'b0000);
    reset_i = 1'b0; mem_dma_data_v_i = 1'b0;
    wait_open(lat);
    check("recalib_latency_ok", (lat >= 2 && lat <= 3), 1'b1);
    mem_dma_pkt_yumi_i = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      mem_dma_data_v_i = 1'b1; core_dma_data_ready_and_i = 1'b1;
      step();
    end
    idle_inputs();
    #1;
    check("post_reset_rd_error", rd_error_o, 1'b0);
    step();
    check("post_reset_done", done_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
